pingpong_bank_ctrl: RTL
=======================

PINGPONG_BANK_CTRL -- requirements
Module: pingpong_bank_ctrl

Interface
REQ-001 Parameter W_S, default 64: width of the transfer size, in words.
REQ-002 Parameter NUM_BANKS, default 2, fixed at 2: the two CoRAM buffers are banks 0 and 1.
REQ-003 CLK  in  1  clock; every register updates on the rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 fill_req  in  1  level: producer requests a bank to fill.
REQ-006 fill_grant  out  1  one-cycle pulse: the bank is allocated to the producer.
REQ-007 fill_bank  out  1  bank index for the grant; valid while fill_grant=1.
REQ-008 fill_done  in  1  one-cycle pulse: the outstanding fill is complete.
REQ-009 fill_size  in  W_S  word count; sampled with fill_done.
REQ-010 cons_valid  out  1  a FULL bank is offered to the consumer.
REQ-011 cons_bank  out  1  index of the offered bank; stable while cons_valid=1.
REQ-012 cons_size  out  W_S  stored fill_size of the offered bank; stable while cons_valid=1.
REQ-013 cons_ready  in  1  consumer accepts the offer.
REQ-014 cons_done  in  1  one-cycle pulse: the consumer releases the bank.
REQ-015 full_count  out  2  number of banks in state FULL or CONSUMING.
REQ-016 proto_err  out  1  sticky protocol-error flag.
REQ-017 stall_cycles  out  32  consumer starvation counter; see Configuration.

Function
REQ-018 Each bank holds one state (EMPTY, FILLING, FULL, CONSUMING) and a W_S-bit size register.
REQ-019 Pointers: next_fill and next_cons, each 1 bit and toggled on completion, so banks are consumed strictly in fill order.
REQ-020 At most one fill and one consume are outstanding at any time.
REQ-021 Grant condition, checked on registered state: fill_req=1, no bank FILLING, bank[next_fill]=EMPTY.
- Next cycle: fill_grant=1 for one cycle, fill_bank=next_fill.
- Same edge: that bank goes to FILLING.
REQ-022 fill_req held high after a grant produces no further grant until the grant condition holds again.
REQ-023 On fill_done with a bank FILLING:
- that bank goes to FULL and stores fill_size;
- next_fill toggles;
- fill_size=0 is stored and forwarded unchanged.
REQ-024 cons_valid is registered and equals (bank[next_cons]=FULL and no bank CONSUMING).
- Asserts 1 cycle after fill_done at the earliest.
REQ-025 A handshake is cons_valid and cons_ready in the same cycle.
- The bank goes to CONSUMING.
- cons_valid drops the next cycle.
REQ-026 On cons_done with a bank CONSUMING: that bank goes to EMPTY and next_cons toggles.
REQ-027 A bank freed by cons_done becomes grantable from the next cycle; no same-cycle bypass.
REQ-028 fill_done and cons_done/handshake in the same cycle act independently; both transitions apply.
REQ-029 Protocol errors set proto_err=1:
- fill_done with no bank FILLING: ignored;
- cons_done with no bank CONSUMING: ignored.
REQ-030 full_count is registered and updates 1 cycle after the causing transition.

Reset
REQ-031 While RST=1:
- both banks EMPTY, both sizes 0;
- next_fill=0, next_cons=0;
- fill_grant=0, cons_valid=0, cons_bank=0, cons_size=0, full_count=0;
- proto_err=0, stall_cycles=0.
REQ-032 RST asserted mid-transfer abandons all in-flight fills and consumes with no error flagged.
REQ-033 proto_err clears only on RST.

Configuration
REQ-034 Macro PINGPONG_BANK_CTRL_STATS_EN defined: stall_cycles counts cycles where cons_valid=0, no bank CONSUMING and no bank FULL.
- Saturates at 32'hFFFFFFFF.
REQ-035 Macro undefined: stall_cycles is constant 0 and no counter logic is generated.

Structure
REQ-036 Package pingpong_bank_pkg holds the 2-bit bank-state encoding: EMPTY=0, FILLING=1, FULL=2, CONSUMING=3.
REQ-037 Sub-module pingpong_bank_slot (per-bank state and size register, with transition inputs) is instantiated twice.

Verification
REQ-038 Reset, then fill_req=1 -> fill_grant pulse next cycle with fill_bank=0; fill_done with size 256 -> cons_valid=1, cons_bank=0, cons_size=256 one cycle later.
REQ-039 Fill bank 0 (size 16), then bank 1 (size 32), with cons_ready=0 throughout.
- full_count=2.
- A third fill_req gets no grant.
- Handshakes then yield bank 0/16 followed by bank 1/32.
REQ-040 cons_done on bank 0 in the same cycle as a pending fill_req -> grant of bank 0 exactly one cycle later.
REQ-041 fill_done with no prior grant -> proto_err=1, bank states unchanged; cons_done while idle -> proto_err stays 1.
REQ-042 With PINGPONG_BANK_CTRL_STATS_EN: 10 idle cycles after reset -> stall_cycles=10. Without it: stall_cycles=0.
REQ-043 RST pulsed while bank 0 is CONSUMING and bank 1 is FILLING -> all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/pingpong_bank_pkg.sv
// -----------------------------------------------------------------------------
// pingpong_bank_pkg
// Shared definitions for the ping-pong bank controller.
//   bank_state_e : 2-bit per-bank state (EMPTY=0, FILLING=1, FULL=2,
//                  CONSUMING=3).
//   bank_holds_data() : true for states that count towards full_count.
// -----------------------------------------------------------------------------
package pingpong_bank_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY     = 2'd0,
    BANK_FILLING   = 2'd1,
    BANK_FULL      = 2'd2,
    BANK_CONSUMING = 2'd3
  } bank_state_e;

  // A bank holds valid data from fill completion until the consumer releases it.
  function automatic logic bank_holds_data(input bank_state_e s);
    return (s == BANK_FULL) || (s == BANK_CONSUMING);
  endfunction

endpackage

// File: rtl/pingpong_bank_slot.sv
// -----------------------------------------------------------------------------
// pingpong_bank_slot
// One CoRAM bank: state register plus stored fill size.
// The top decides which bank a transition targets; the slot only applies a
// transition when it is in the matching source state.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   grant_i       EMPTY     -> FILLING
//   fill_done_i   FILLING   -> FULL, size <= fill_size_i
//   fill_size_i   word count captured with fill_done_i
//   accept_i      FULL      -> CONSUMING (consumer handshake)
//   release_i     CONSUMING -> EMPTY
//   state_o       registered state (also the debug view of this FSM)
//   state_d_o     next state, used by the top to register cons_valid
//   size_d_o      next stored size, used by the top to register cons_size
// -----------------------------------------------------------------------------
module pingpong_bank_slot
  import pingpong_bank_pkg::*;
#(
  parameter int W_S = 64
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           grant_i,
  input  logic           fill_done_i,
  input  logic [W_S-1:0] fill_size_i,
  input  logic           accept_i,
  input  logic           release_i,
  output bank_state_e    state_o,
  output bank_state_e    state_d_o,
  output logic [W_S-1:0] size_d_o
);

  bank_state_e    state_q, state_d;
  logic [W_S-1:0] size_q, size_d;

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    case (state_q)
      BANK_EMPTY:     if (grant_i) state_d = BANK_FILLING;
      BANK_FILLING:   if (fill_done_i) begin
                        state_d = BANK_FULL;
                        size_d  = fill_size_i;
                      end
      BANK_FULL:      if (accept_i) state_d = BANK_CONSUMING;
      BANK_CONSUMING: if (release_i) state_d = BANK_EMPTY;
      default:        state_d = BANK_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= BANK_EMPTY;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
    end
  end

  assign state_o   = state_q;
  assign state_d_o = state_d;
  assign size_d_o  = size_d;

endmodule

// File: rtl/pingpong_bank_ctrl.sv
// -----------------------------------------------------------------------------
// pingpong_bank_ctrl
// Ping-pong controller for two CoRAM banks between one producer and one
// consumer. Banks are filled and consumed strictly in order via two 1-bit
// pointers (next_fill / next_cons) that toggle on completion.
//
// Optional feature: define PINGPONG_BANK_CTRL_STATS_EN to build the
// consumer-starvation counter on stall_cycles; otherwise it is tied to 0.
//
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   fill_req         producer asks for a bank (level)
//   fill_grant       one-cycle grant pulse, fill_bank = granted bank
//   fill_done        one-cycle fill completion, fill_size sampled with it
//   cons_valid       a FULL bank is offered; cons_bank / cons_size describe it
//   cons_ready       consumer accepts the offer
//   cons_done        one-cycle pulse, consumer releases its bank
//   full_count       banks in FULL or CONSUMING, one cycle behind the state
//   proto_err        sticky: stray fill_done or cons_done seen
//   stall_cycles     starvation cycles (see macro above)
//   dbg_bank_state   {bank1, bank0} registered bank states
//
// Consumer handshake: the offer transfers on any rising edge where
// cons_valid=1 and cons_ready=1. cons_valid is registered from next-state
// values, so it drops in the cycle right after the handshake and cons_bank /
// cons_size stay constant for as long as it is held.
// -----------------------------------------------------------------------------
module pingpong_bank_ctrl
  import pingpong_bank_pkg::*;
#(
  parameter int W_S       = 64,
  parameter int NUM_BANKS = 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           fill_req,
  output logic           fill_grant,
  output logic           fill_bank,
  input  logic           fill_done,
  input  logic [W_S-1:0] fill_size,
  output logic           cons_valid,
  output logic           cons_bank,
  output logic [W_S-1:0] cons_size,
  input  logic           cons_ready,
  input  logic           cons_done,
  output logic [1:0]     full_count,
  output logic           proto_err,
  output logic [31:0]    stall_cycles,
  output logic [3:0]     dbg_bank_state
);

  bank_state_e    st_q [NUM_BANKS];
  bank_state_e    st_d [NUM_BANKS];
  logic [W_S-1:0] sz_d [NUM_BANKS];

  logic           next_fill_q, next_fill_d;
  logic           next_cons_q, next_cons_d;
  logic           fill_grant_q, fill_bank_q;
  logic           cons_valid_q, cons_bank_q;
  logic [W_S-1:0] cons_size_q;
  logic [1:0]     full_count_q;
  logic           proto_err_q;

  logic       any_filling, any_consuming, any_consuming_d;
  logic [1:0] occ_cnt;
  logic       grant_go, fill_go, hs_go, rel_go, perr_go;

  always_comb begin
    any_filling     = 1'b0;
    any_consuming   = 1'b0;
    any_consuming_d = 1'b0;
    occ_cnt         = 2'd0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (st_q[b] == BANK_FILLING)   any_filling     = 1'b1;
      if (st_q[b] == BANK_CONSUMING) any_consuming   = 1'b1;
      if (st_d[b] == BANK_CONSUMING) any_consuming_d = 1'b1;
      if (bank_holds_data(st_q[b]))  occ_cnt         = occ_cnt + 2'd1;
    end
  end

  // Only one fill and one consume can be outstanding, and both follow the
  // pointers, so the FILLING bank is always next_fill and the CONSUMING bank
  // is always next_cons.
  assign grant_go = fill_req && !any_filling && (st_q[next_fill_q] == BANK_EMPTY);
  assign fill_go  = fill_done && any_filling;
  assign hs_go    = cons_valid_q && cons_ready;
  assign rel_go   = cons_done && any_consuming;
  assign perr_go  = (fill_done && !any_filling) || (cons_done && !any_consuming);

  assign next_fill_d = next_fill_q ^ fill_go;
  assign next_cons_d = next_cons_q ^ rel_go;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_slot
    pingpong_bank_slot #(.W_S(W_S)) u_slot (
      .CLK         (CLK),
      .RST         (RST),
      .grant_i     (grant_go && (next_fill_q == 1'(b))),
      .fill_done_i (fill_go  && (next_fill_q == 1'(b))),
      .fill_size_i (fill_size),
      .accept_i    (hs_go    && (next_cons_q == 1'(b))),
      .release_i   (rel_go   && (next_cons_q == 1'(b))),
      .state_o     (st_q[b]),
      .state_d_o   (st_d[b]),
      .size_d_o    (sz_d[b])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      next_fill_q  <= 1'b0;
      next_cons_q  <= 1'b0;
      fill_grant_q <= 1'b0;
      fill_bank_q  <= 1'b0;
      cons_valid_q <= 1'b0;
      cons_bank_q  <= 1'b0;
      cons_size_q  <= '0;
      full_count_q <= 2'd0;
      proto_err_q  <= 1'b0;
    end else begin
      next_fill_q  <= next_fill_d;
      next_cons_q  <= next_cons_d;
      fill_grant_q <= grant_go;
      if (grant_go) fill_bank_q <= next_fill_q;
      // Registered from next-state so the offer appears the cycle after
      // fill_done and disappears the cycle after the handshake.
      cons_valid_q <= (st_d[next_cons_d] == BANK_FULL) && !any_consuming_d;
      cons_bank_q  <= next_cons_d;
      cons_size_q  <= sz_d[next_cons_d];
      // Counted from the current state, so it trails the transition by one.
      full_count_q <= occ_cnt;
      if (perr_go) proto_err_q <= 1'b1;
    end
  end

`ifdef PINGPONG_BANK_CTRL_STATS_EN
  logic [31:0] stall_q;

  // Starved: nothing offered, nothing being consumed, nothing waiting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
    end else if (!cons_valid_q && (occ_cnt == 2'd0) && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

  assign fill_grant     = fill_grant_q;
  assign fill_bank      = fill_bank_q;
  assign cons_valid     = cons_valid_q;
  assign cons_bank      = cons_bank_q;
  assign cons_size      = cons_size_q;
  assign full_count     = full_count_q;
  assign proto_err      = proto_err_q;
  assign dbg_bank_state = {st_q[1], st_q[0]};

endmodule
